// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types for the 5-stage core.
// Stage indices, the en/flush bundle and the redirect FSM states.
package pipe_ctrl_pkg;

  localparam int SEL_FD = 0;
  localparam int SEL_DE = 1;
  localparam int SEL_EM = 2;
  localparam int SEL_MW = 3;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] flush;
  } pipe_ctrl_t;

  typedef enum logic {
    RUN,
    WAIT_IMEM
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && count != '1)
      count <= count + ONE;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, redirect delivery
// and performance counters for the four pipewire registers.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PC_W  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stall,
  input  logic             load_use,
  input  logic             ex_busy,
  input  logic             d_stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [3:0]       en,
  output logic [3:0]       flush,
  output logic             pc_redir_valid,
  output logic [PC_W-1:0]  pc_redir,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  ctrl_state_t     state, state_nx;
  logic [PC_W-1:0] held_pc, held_pc_nx;
  pipe_ctrl_t      ctl;
  logic            accept;

  // EX cannot hand over a redirect while MEM or EX itself is frozen
  assign accept = redirect_valid & ~d_stall & ~ex_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      held_pc <= '0;
    end else begin
      state   <= state_nx;
      held_pc <= held_pc_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    held_pc_nx = held_pc;
    unique case (state)
      RUN: begin
        if (accept && i_stall) begin
          state_nx   = WAIT_IMEM;
          held_pc_nx = redirect_pc;
        end
      end
      WAIT_IMEM: begin
        if (accept)
          held_pc_nx = redirect_pc;
        if (!i_stall)
          state_nx = RUN;
      end
    endcase
  end

  always_comb begin
    ctl.en         = 4'b1111;
    ctl.flush      = 4'b0000;
    pc_redir_valid = 1'b0;
    pc_redir       = '0;
    if (reset) begin
      ctl.flush = 4'b1111;
    end else begin
      priority case (1'b1)
        d_stall: ctl.en = 4'b0000;
        ex_busy: begin
          ctl.en    = 4'b1100;
          ctl.flush = 4'b0100;
        end
        load_use: begin
          ctl.en    = 4'b1110;
          ctl.flush = 4'b0010;
        end
        i_stall: ctl.flush = 4'b0001;
        default: ;
      endcase
      if (accept) begin
        ctl.en[SEL_DE:SEL_FD]    = 2'b11;
        ctl.flush[SEL_DE:SEL_FD] = 2'b11;
      end
      unique case (state)
        RUN: begin
          if (accept && !i_stall) begin
            pc_redir_valid = 1'b1;
            pc_redir       = redirect_pc;
          end
        end
        WAIT_IMEM: begin
          // returning fetch is wrong-path; drop it
          ctl.flush[SEL_FD] = 1'b1;
          if (!i_stall) begin
            pc_redir_valid = 1'b1;
            pc_redir       = accept ? redirect_pc : held_pc;
          end
        end
      endcase
    end
  end

  assign en    = ctl.en;
  assign flush = ctl.flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~ctl.en[SEL_FD]),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_redir_valid),
    .count (redir_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then
// random traffic against a pending-redirect reference model.
module tb_pipe_ctrl;

  localparam int CW   = 4;
  localparam int PW   = 64;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b1;
  logic          reset;
  logic          i_stall, load_use, ex_busy, d_stall;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic [3:0]    en, flush;
  logic          pc_redir_valid;
  logic [PW-1:0] pc_redir;
  logic [CW-1:0] stall_cnt, redir_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CW), .PC_W(PW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_stall        (i_stall),
    .load_use       (load_use),
    .ex_busy        (ex_busy),
    .d_stall        (d_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .en             (en),
    .flush          (flush),
    .pc_redir_valid (pc_redir_valid),
    .pc_redir       (pc_redir),
    .stall_cnt      (stall_cnt),
    .redir_cnt      (redir_cnt)
  );

  typedef struct {
    logic [3:0]    en;
    logic [3:0]    flush;
    logic          pv;
    logic [PW-1:0] pc;
    logic          ck;
    int            sc;
    int            rc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model: at most one pending redirect target
  bit            m_pend;
  logic [PW-1:0] m_tgt;
  int            m_sc, m_rc;

  task automatic check(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step(input bit r, input bit is, input bit lu,
                      input bit ex, input bit ds, input bit rv,
                      input logic [PW-1:0] rpc);
    exp_t e;
    bit   acc;
    reset          = r;
    i_stall        = is;
    load_use       = lu;
    ex_busy        = ex;
    d_stall        = ds;
    redirect_valid = rv;
    redirect_pc    = rpc;
    e.pv = 1'b0;
    e.pc = '0;
    e.ck = !r;
    e.sc = m_sc;
    e.rc = m_rc;
    if (r) begin
      e.en    = 4'b1111;
      e.flush = 4'b1111;
      m_pend  = 0;
      m_tgt   = '0;
      m_sc    = 0;
      m_rc    = 0;
    end else begin
      if (ds) begin
        e.en = 4'b0000; e.flush = 4'b0000;
      end else if (ex) begin
        e.en = 4'b1100; e.flush = 4'b0100;
      end else if (lu) begin
        e.en = 4'b1110; e.flush = 4'b0010;
      end else if (is) begin
        e.en = 4'b1111; e.flush = 4'b0001;
      end else begin
        e.en = 4'b1111; e.flush = 4'b0000;
      end
      acc = rv && !ds && !ex;
      if (acc) begin
        e.en[1:0]    = 2'b11;
        e.flush[1:0] = 2'b11;
      end
      if (m_pend)
        e.flush[0] = 1'b1;
      if (acc) begin
        m_pend = 1;
        m_tgt  = rpc;
      end
      if (m_pend && !is) begin
        e.pv   = 1'b1;
        e.pc   = m_tgt;
        m_pend = 0;
      end
      if (!e.en[0] && m_sc < CMAX) m_sc++;
      if (e.pv && m_rc < CMAX) m_rc++;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("en", 64'(en), 64'(e.en));
      check("flush", 64'(flush), 64'(e.flush));
      check("pc_redir_valid", 64'(pc_redir_valid), 64'(e.pv));
      check("pc_redir", pc_redir, e.pc);
      if (e.ck) begin
        check("stall_cnt", 64'(stall_cnt), 64'(e.sc));
        check("redir_cnt", 64'(redir_cnt), 64'(e.rc));
      end
    end
  end

  initial begin
    logic [PW-1:0] rpc;
    bit r, is, lu, ex, ds, rv;
    step(1, 0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    idle(2);
    step(0, 0, 1, 0, 0, 0, '0);
    idle(1);
    step(0, 0, 1, 0, 0, 1, 64'h8000_0040);
    idle(2);
    step(0, 1, 0, 0, 0, 1, 64'h8000_0100);
    step(0, 1, 0, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);
    idle(1);
    step(0, 0, 1, 1, 1, 1, 64'h8000_0300);
    step(0, 0, 0, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, 1, 64'h8000_0100);
    step(0, 1, 0, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, 1, 64'h8000_0200);
    step(0, 0, 0, 0, 0, 0, '0);
    idle(1);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 0, '0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, '0);
    rpc = 64'h8000_0000;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 99) < 1);
      is = ($urandom_range(0, 99) < 35);
      lu = ($urandom_range(0, 99) < 15);
      ex = ($urandom_range(0, 99) < 10);
      ds = ($urandom_range(0, 99) < 10);
      rv = ($urandom_range(0, 99) < 25);
      if (rv) rpc = 64'h8000_0000 + 64'($urandom_range(0, 4095) * 4);
      step(r, is, lu, ex, ds, rv, rpc);
    end
    idle(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control for the 5-stage core: produces the `en`/`flush_en` pair consumed by each of the four inter-stage pipewire registers (F/D, D/E, E/M, M/W).
- Arbitrates stall sources: imem busy, load-use, multi-cycle execute, dmem busy.
- Arbitrates branch/jump redirects from EX; holds a redirect pending while an instruction fetch is in flight.
- Counts stall and redirect cycles for performance reporting.

Parameters:
- CNT_W, 32, width of the performance counters (saturating).
- PC_W, 64, width of the redirect PC.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- i_stall  in  1  fetch request outstanding (imem busy)
- load_use  in  1  decode needs the result of a load currently in EX
- ex_busy  in  1  multi-cycle EX unit (mul/div) not done
- d_stall  in  1  dmem access outstanding in MEM
- redirect_valid  in  1  EX resolved a taken branch/jump or mispredict
- redirect_pc  in  PC_W  target PC of the redirect
- en  out  4  capture enable per register; bit 0=F/D, 1=D/E, 2=E/M, 3=M/W
- flush  out  4  bubble-insert per register, same indexing
- pc_redir_valid  out  1  fetch must load pc_redir this cycle
- pc_redir  out  PC_W  PC for fetch
- stall_cnt  out  CNT_W  cycles with en[0]=0
- redir_cnt  out  CNT_W  redirects delivered to fetch

Behaviour:
- One clock domain (`clk`). Synchronous active-high `reset`.
- en/flush/pc_redir_* are combinational from inputs and state. Counters and state are registered.
- While reset=1: en=4'b1111, flush=4'b1111 (all pipewires clear), pc_redir_valid=0, pc_redir=0.
- Next edge under reset: state=RUN, held_pc=0, both counters=0.
- Stall priority, highest first. Default is en=1111, flush=0000.
  1. d_stall: en=0000, flush=0000 (full freeze).
  2. ex_busy: en=1100, flush=0100 (bubble into E/M).
  3. load_use: en=1110, flush=0010 (bubble into D/E).
  4. i_stall: en=1111, flush=0001 (bubble into F/D).
- Redirect is accepted only when d_stall=0 and ex_busy=0. EX holds redirect_valid/redirect_pc stable while stalled.
- Accepted redirect forces flush[1:0]=11 and en[1:0]=11, overriding load_use and i_stall bubbles.
- States: RUN, WAIT_IMEM.
- RUN:
  - Accepted redirect with i_stall=0: pc_redir_valid=1, pc_redir=redirect_pc, redir_cnt+1. Stay RUN.
  - Accepted redirect with i_stall=1: latch held_pc=redirect_pc, go to WAIT_IMEM, pc_redir_valid=0. The in-flight fetch is for the wrong path.
- WAIT_IMEM:
  - flush[0]=1 every cycle, so the returning wrong-path fetch is discarded.
  - When i_stall=0: pc_redir_valid=1, pc_redir=held_pc, redir_cnt+1, next state RUN.
  - A new accepted redirect while in WAIT_IMEM overwrites held_pc; the newer one wins.
  - If i_stall=0 in that same cycle, redirect_pc is delivered directly.
- Counters saturate at all-ones and never wrap.
  - stall_cnt increments when en[0]=0.
  - redir_cnt increments on each cycle with pc_redir_valid=1.
- Reset mid-WAIT_IMEM drops the held redirect. Pipeline restart comes from the reset vector.

Decomposition:
- Shared pipes package:
  - stage-index constants (SEL_FD=0, SEL_DE=1, SEL_EM=2, SEL_MW=3);
  - typedef pipe_ctrl_t {en[3:0], flush[3:0]};
  - enum ctrl_state_t {RUN, WAIT_IMEM}.
- One natural sub-module: sat_counter (parameterized width, inc, synchronous reset). Instantiated twice.

Test Plan:
- Reset: hold reset 2 cycles, then release with all inputs 0 -> during reset en=1111, flush=1111; after release en=1111, flush=0000, stall_cnt=0, redir_cnt=0.
- Load-use with redirect:
  - load_use=1 for 1 cycle -> en=1110, flush=0010, stall_cnt=1.
  - Same cycle plus redirect_valid=1, redirect_pc=0x8000_0040 -> flush=0011, en=1111, pc_redir_valid=1, pc_redir=0x8000_0040.
- Redirect during fetch stall:
  - Redirect to 0x8000_0100 while i_stall=1 for 3 cycles -> pc_redir_valid=0 and flush[0]=1 for 3 cycles.
  - Cycle i_stall falls -> pc_redir_valid=1, pc_redir=0x8000_0100, redir_cnt=1.
- Precedence: d_stall=1 together with ex_busy=1, load_use=1, redirect_valid=1 -> en=0000, flush=0000, redirect not accepted, state unchanged.
- Overwrite: second redirect 0x8000_0200 arrives while in WAIT_IMEM -> 0x8000_0200 delivered, 0x8000_0100 never appears on pc_redir.
- Saturation: CNT_W=4, stall 20 cycles with load_use=1 -> stall_cnt stops at 15.
